// File: rtl/cheri_tsmap_arbiter_pkg.sv
// Shared types for the temporal-safety map arbiter.
// Contents: bus operation encoding, arbiter FSM states, and the
// read-modify-write data function used for SET/CLR updates.
package cheri_tsmap_arbiter_pkg;

  localparam int unsigned TsmapDataW = 32;

  typedef enum logic [1:0] {
    TSMAP_OP_READ  = 2'd0,
    TSMAP_OP_WRITE = 2'd1,
    TSMAP_OP_SET   = 2'd2,
    TSMAP_OP_CLR   = 2'd3
  } tsmap_op_e;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'd0,
    ARB_RD   = 3'd1,
    ARB_RDW  = 3'd2,
    ARB_WR   = 3'd3,
    ARB_RESP = 3'd4,
    ARB_ERR  = 3'd5
  } tsmap_arb_state_e;

  // New word value written back for a bus operation.
  function automatic logic [TsmapDataW-1:0] tsmap_rmw(
    input tsmap_op_e             op,
    input logic [TsmapDataW-1:0] old_word,
    input logic [TsmapDataW-1:0] operand
  );
    logic [TsmapDataW-1:0] res;
    case (op)
      TSMAP_OP_SET: res = old_word | operand;
      TSMAP_OP_CLR: res = old_word & ~operand;
      default:      res = operand;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cheri_tsmap_arbiter.sv
// Arbitrates the single-port TS map SRAM between the core's read-only
// tsmap port (absolute priority, no stall) and a bus requester that can
// READ, WRITE, SET or CLR words; SET/CLR run as read-modify-write in the
// gaps between core reads.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   core_tsmap_*                 core read port; data returns next cycle
//   bus_req_i/bus_gnt_o          bus request handshake (one outstanding)
//   bus_op_i/addr_i/wdata_i      bus operation, word address, data/mask
//   bus_rvalid_o/rdata_o/err_o   one-cycle bus response
//   ram_*                        SRAM macro interface
//   contention_cnt_o             saturating count of core-blocked cycles
module cheri_tsmap_arbiter
  import cheri_tsmap_arbiter_pkg::*;
#(
  parameter int unsigned TSMapSize = 1024,
  parameter int unsigned AddrW     = 16,
  parameter int unsigned CntW      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             core_tsmap_cs_i,
  input  logic [AddrW-1:0] core_tsmap_addr_i,
  output logic [31:0]      core_tsmap_rdata_o,
  input  logic             bus_req_i,
  output logic             bus_gnt_o,
  input  logic [1:0]       bus_op_i,
  input  logic [AddrW-1:0] bus_addr_i,
  input  logic [31:0]      bus_wdata_i,
  output logic             bus_rvalid_o,
  output logic [31:0]      bus_rdata_o,
  output logic             bus_err_o,
  output logic             ram_req_o,
  output logic             ram_we_o,
  output logic [AddrW-1:0] ram_addr_o,
  output logic [31:0]      ram_wdata_o,
  input  logic [31:0]      ram_rdata_i,
  output logic [CntW-1:0]  contention_cnt_o
);

  tsmap_arb_state_e state_q, state_d;
  tsmap_op_e        op_q, op_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      old_q, old_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic             addr_err;
  logic             fsm_rd;
  logic             fsm_wr;
  logic [31:0]      wr_val;

  assign addr_err = (32'(bus_addr_i) >= TSMapSize);
  assign wr_val   = tsmap_rmw(op_q, old_q, wdata_q);

  // Next-state, datapath capture and FSM SRAM requests.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    old_d     = old_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    bus_gnt_o = 1'b0;
    fsm_rd    = 1'b0;
    fsm_wr    = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        bus_gnt_o = bus_req_i;
        if (bus_req_i) begin
          op_d    = tsmap_op_e'(bus_op_i);
          addr_d  = bus_addr_i;
          wdata_d = bus_wdata_i;
          if (addr_err) begin
            rdata_d = '0;
            state_d = ARB_ERR;
          end else if (tsmap_op_e'(bus_op_i) == TSMAP_OP_WRITE) begin
            state_d = ARB_WR;
          end else begin
            state_d = ARB_RD;
          end
        end
      end
      ARB_RD: begin
        if (core_tsmap_cs_i) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
        end else begin
          fsm_rd  = 1'b1;
          state_d = ARB_RDW;
        end
      end
      ARB_RDW: begin
        // SRAM data here belongs to the RD-cycle issue, whatever the core does now.
        old_d = ram_rdata_i;
        if (op_q == TSMAP_OP_READ) begin
          rdata_d = ram_rdata_i;
          state_d = ARB_RESP;
        end else begin
          state_d = ARB_WR;
        end
      end
      ARB_WR: begin
        if (core_tsmap_cs_i) begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CntW'(1);
        end else begin
          fsm_wr  = 1'b1;
          rdata_d = (op_q == TSMAP_OP_WRITE) ? 32'h0 : old_q;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      ARB_ERR:  state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase

    // Reset drops the transaction before anything reaches the SRAM or bus.
    if (rst_i) begin
      bus_gnt_o = 1'b0;
      fsm_rd    = 1'b0;
      fsm_wr    = 1'b0;
    end
  end

  // SRAM mux: the core always wins, the FSM fills free cycles.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = core_tsmap_addr_i;
    ram_wdata_o = 32'h0;
    if (core_tsmap_cs_i) begin
      ram_req_o = 1'b1;
    end else if (fsm_rd) begin
      ram_req_o  = 1'b1;
      ram_addr_o = addr_q;
    end else if (fsm_wr) begin
      ram_req_o   = 1'b1;
      ram_we_o    = 1'b1;
      ram_addr_o  = addr_q;
      ram_wdata_o = wr_val;
    end
  end

  assign core_tsmap_rdata_o = ram_rdata_i;
  assign bus_rvalid_o       = ~rst_i & ((state_q == ARB_RESP) | (state_q == ARB_ERR));
  assign bus_err_o          = ~rst_i & (state_q == ARB_ERR);
  assign bus_rdata_o        = rdata_q;
  assign contention_cnt_o   = cnt_q;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      op_q    <= TSMAP_OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      old_q   <= old_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cheri_tsmap_arbiter.sv
// Bench for cheri_tsmap_arbiter: SRAM macro model, a transaction-level
// reference of the TS map contents and bus responses, a per-cycle compare
// process, and directed scenarios with literal expectations.
module tb_cheri_tsmap_arbiter;

  localparam int unsigned MAP = 1024;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        core_cs = 1'b0;
  logic [15:0] core_addr = 16'h0;
  logic [31:0] core_rdata;
  logic        bus_req = 1'b0;
  logic        bus_gnt;
  logic [1:0]  bus_op = 2'd0;
  logic [15:0] bus_addr = 16'h0;
  logic [31:0] bus_wdata = 32'h0;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        bus_err;
  logic        ram_req;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0;
  logic [15:0] cnt;

  always #5 clk = ~clk;

  cheri_tsmap_arbiter #(.TSMapSize(1024), .AddrW(16), .CntW(16)) dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .core_tsmap_cs_i    (core_cs),
    .core_tsmap_addr_i  (core_addr),
    .core_tsmap_rdata_o (core_rdata),
    .bus_req_i          (bus_req),
    .bus_gnt_o          (bus_gnt),
    .bus_op_i           (bus_op),
    .bus_addr_i         (bus_addr),
    .bus_wdata_i        (bus_wdata),
    .bus_rvalid_o       (bus_rvalid),
    .bus_rdata_o        (bus_rdata),
    .bus_err_o          (bus_err),
    .ram_req_o          (ram_req),
    .ram_we_o           (ram_we),
    .ram_addr_o         (ram_addr),
    .ram_wdata_o        (ram_wdata),
    .ram_rdata_i        (ram_rdata),
    .contention_cnt_o   (cnt)
  );

  // Single-port SRAM macro: read data one cycle after the request.
  logic [31:0] sram [MAP];
  always @(posedge clk) begin
    if (ram_req && (32'(ram_addr) < MAP)) begin
      if (ram_we) sram[ram_addr[9:0]] <= ram_wdata;
      else        ram_rdata <= sram[ram_addr[9:0]];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: map contents as the bus sees them, one entry per granted op.
  typedef struct {
    int          op;
    int          addr;
    logic        err;
    logic [31:0] old;
    logic [31:0] rdata;
    logic [31:0] newv;
    int          tg;
  } exp_t;

  logic [31:0] ref_mem [MAP];
  exp_t        pend[$];
  bit          busy = 1'b0;
  logic        rst_prev = 1'b0;
  logic        cs_prev = 1'b0;
  logic [31:0] core_exp = 32'h0;

  function automatic int min_lat(input exp_t e);
    if (e.err) return 1;
    case (e.op)
      0:       return 3;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  // Per-cycle compare against the reference model.
  always @(negedge clk) begin
    exp_t e;
    if (rst_prev) begin
      chk("rst_rdata", bus_rdata, 32'h0);
      chk("rst_cnt", 32'(cnt), 32'h0);
    end
    if (rst_i) begin
      chk("rst_gnt", 32'(bus_gnt), 32'h0);
      chk("rst_rvalid", 32'(bus_rvalid), 32'h0);
      chk("rst_we", 32'(ram_we), 32'h0);
      // A dropped write never commits.
      if (pend.size() != 0 && !pend[0].err && pend[0].op != 0)
        ref_mem[pend[0].addr] = pend[0].old;
      pend.delete();
      busy = 1'b0;
    end else begin
      if (core_cs) begin
        chk("core_req", 32'(ram_req), 32'h1);
        chk("core_we", 32'(ram_we), 32'h0);
        chk("core_addr", 32'(ram_addr), 32'(core_addr));
      end
      if (cs_prev) chk("core_rdata", core_rdata, core_exp);
      chk("gnt", 32'(bus_gnt), 32'(bus_req && !busy));

      if (ram_req && !core_cs) begin
        if (pend.size() == 0) begin
          chk("spurious_ram", 32'(ram_req), 32'h0);
        end else begin
          e = pend[0];
          chk("ram_access_allowed", 32'(ram_req), 32'(!e.err));
          chk("ram_addr", 32'(ram_addr), 32'(e.addr));
          if (ram_we) begin
            chk("ram_we_op", 32'(e.op != 0), 32'h1);
            chk("ram_wdata", ram_wdata, e.newv);
          end else begin
            chk("ram_rd_op", 32'(e.op != 1), 32'h1);
          end
        end
      end

      if (bus_gnt) begin
        e.op   = int'(bus_op);
        e.addr = int'(bus_addr);
        e.tg   = cyc;
        e.err  = (32'(bus_addr) >= MAP);
        if (e.err) begin
          e.old = 32'h0; e.rdata = 32'h0; e.newv = 32'h0;
        end else begin
          e.old = ref_mem[e.addr];
          case (e.op)
            0: begin e.rdata = e.old; e.newv = e.old; end
            1: begin e.rdata = 32'h0; e.newv = bus_wdata; end
            2: begin e.rdata = e.old; e.newv = e.old | bus_wdata; end
            default: begin e.rdata = e.old; e.newv = e.old & ~bus_wdata; end
          endcase
          ref_mem[e.addr] = e.newv;
        end
        pend.push_back(e);
        busy = 1'b1;
      end

      if (bus_rvalid) begin
        if (pend.size() == 0) begin
          chk("rvalid_unexpected", 32'(bus_rvalid), 32'h0);
        end else begin
          e = pend.pop_front();
          chk("resp_rdata", bus_rdata, e.rdata);
          chk("resp_err", 32'(bus_err), 32'(e.err));
          chk("resp_latency_min", 32'((cyc - e.tg) >= min_lat(e)), 32'h1);
          if (!e.err && e.op != 0) chk("committed_word", sram[e.addr], e.newv);
        end
        busy = 1'b0;
      end
    end
    rst_prev = rst_i;
    cs_prev  = core_cs;
    core_exp = (32'(core_addr) < MAP) ? sram[core_addr[9:0]] : 32'h0;
  end

  task automatic bus_go(input logic [1:0] op, input logic [15:0] a, input logic [31:0] wd,
                        output int t);
    @(posedge clk); #1;
    bus_req = 1'b1; bus_op = op; bus_addr = a; bus_wdata = wd;
    @(negedge clk);
    chk("dir_gnt", 32'(bus_gnt), 32'h1);
    t = cyc;
    @(posedge clk); #1;
    bus_req = 1'b0;
  endtask

  task automatic wait_rv(input int t, output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus_rvalid) begin
        lat = cyc - t; rd = bus_rdata; er = bus_err;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL rvalid_timeout: no response within 60 cycles of grant at cycle %0d", t);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t, lat;
    logic [31:0] rd;
    logic er;
    for (int i = 0; i < int'(MAP); i++) begin
      sram[i]    = 32'(i) * 32'h0101_0101;
      ref_mem[i] = 32'(i) * 32'h0101_0101;
    end
    sram[5] = 32'hA5A5_0000; ref_mem[5] = 32'hA5A5_0000;
    sram[7] = 32'h0000_0001; ref_mem[7] = 32'h0000_0001;
    sram[3] = 32'h0;         ref_mem[3] = 32'h0;
    sram[9] = 32'h1234_5678; ref_mem[9] = 32'h1234_5678;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("init_gnt", 32'(bus_gnt), 32'h0);
    chk("init_rvalid", 32'(bus_rvalid), 32'h0);
    chk("init_rdata", bus_rdata, 32'h0);
    chk("init_cnt", 32'(cnt), 32'h0);
    chk("init_we", 32'(ram_we), 32'h0);

    // READ addr 5 with idle core.
    bus_go(2'd0, 16'd5, 32'h0, t);
    @(negedge clk);
    chk("read_issue_req", 32'(ram_req), 32'h1);
    chk("read_issue_we", 32'(ram_we), 32'h0);
    chk("read_issue_addr", 32'(ram_addr), 32'd5);
    wait_rv(t, lat, rd, er);
    chk("read_lat", 32'(lat), 32'd3);
    chk("read_rdata", rd, 32'hA5A5_0000);
    chk("read_err", 32'(er), 32'h0);
    @(negedge clk);
    chk("hold_rvalid", 32'(bus_rvalid), 32'h0);
    chk("hold_rdata", bus_rdata, 32'hA5A5_0000);

    // SET then CLR on addr 7.
    bus_go(2'd2, 16'd7, 32'h0000_0F00, t);
    wait_rv(t, lat, rd, er);
    chk("set_lat", 32'(lat), 32'd4);
    chk("set_rdata", rd, 32'h0000_0001);
    chk("set_word", sram[7], 32'h0000_0F01);
    bus_go(2'd3, 16'd7, 32'h0000_0001, t);
    wait_rv(t, lat, rd, er);
    chk("clr_lat", 32'(lat), 32'd4);
    chk("clr_rdata", rd, 32'h0000_0F01);
    chk("clr_word", sram[7], 32'h0000_0F00);

    // Core reads addr 7 between the RMW read and its write.
    bus_go(2'd2, 16'd7, 32'h0000_00F0, t);
    @(posedge clk); #1 core_cs = 1'b1; core_addr = 16'd7;
    @(posedge clk); #1 core_cs = 1'b0;
    @(negedge clk);
    chk("interleave_core_old", core_rdata, 32'h0000_0F00);
    @(posedge clk); #1 core_cs = 1'b1;
    @(negedge clk);
    chk("interleave_rvalid", 32'(bus_rvalid), 32'h1);
    chk("interleave_lat", 32'(cyc - t), 32'd4);
    chk("interleave_rdata", bus_rdata, 32'h0000_0F00);
    @(posedge clk); #1 core_cs = 1'b0;
    @(negedge clk);
    chk("interleave_core_new", core_rdata, 32'h0000_0FF0);

    // Core holds the SRAM for 10 cycles during a pending WRITE.
    bus_go(2'd1, 16'd3, 32'hCAFE_0003, t);
    core_addr = 16'd3; core_cs = 1'b1;
    repeat (9) begin @(posedge clk); #1; end
    @(posedge clk); #1 core_cs = 1'b0;
    wait_rv(t, lat, rd, er);
    chk("contend_lat", 32'(lat), 32'd12);
    chk("contend_cnt", 32'(cnt), 32'd10);
    chk("contend_rdata", rd, 32'h0);
    chk("contend_word", sram[3], 32'hCAFE_0003);

    // Out-of-range address.
    bus_go(2'd0, 16'd1024, 32'h0, t);
    wait_rv(t, lat, rd, er);
    chk("err_lat", 32'(lat), 32'd1);
    chk("err_flag", 32'(er), 32'h1);
    chk("err_rdata", rd, 32'h0);
    chk("err_no_ram", 32'(ram_req), 32'h0);

    // Reset while in WR with the core idle.
    bus_go(2'd1, 16'd9, 32'hDEAD_BEEF, t);
    rst_i = 1'b1;
    @(posedge clk); #1 rst_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_drop_rvalid", 32'(bus_rvalid), 32'h0);
    end
    chk("rst_drop_word", sram[9], 32'h1234_5678);
    chk("rst_drop_cnt", 32'(cnt), 32'h0);
    bus_go(2'd0, 16'd9, 32'h0, t);
    wait_rv(t, lat, rd, er);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_rdata", rd, 32'h1234_5678);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
